// File: rtl/deser_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
package deser_pkg;

    localparam int unsigned DESER_W = 16;
    localparam int unsigned MOD_W   = $clog2(DESER_W);

    // Bit count encoded like the serializer's data_mod: a full word reads as 0.
    function automatic int unsigned mod_of(input int unsigned count, input int unsigned w);
        return count % w;
    endfunction

endpackage

// File: rtl/deser_out_slot.sv
// Single-entry valid/ready output register; refuses new words while a held word is unaccepted.
module deser_out_slot #(
    parameter int unsigned W     = 16,
    parameter int unsigned MOD_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic [MOD_W-1:0] push_mod,
    input  logic             ready,
    output logic [W-1:0]     data,
    output logic [MOD_W-1:0] mod,
    output logic             val,
    output logic             overflow
);

    logic free;
    logic load;
    logic drop;
    logic val_nxt;

    // Slot is reusable in the same cycle its word is accepted.
    always_comb begin
        free    = !val || ready;
        load    = push && free;
        drop    = push && !free;
        val_nxt = val;
        if (load) begin
            val_nxt = 1'b1;
        end else if (ready) begin
            val_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            mod      <= '0;
            val      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                data <= push_data;
                mod  <= push_mod;
            end
            val <= val_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/deserializer.sv
// Reassembles an MSB-first serial bit stream into left-aligned parallel words with flush support.
module deserializer
    import deser_pkg::DESER_W, deser_pkg::mod_of;
#(
    parameter  int unsigned W     = DESER_W,
    localparam int unsigned MOD_W = $clog2(W)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    input  logic             flush_i,
    output logic [W-1:0]     deser_data_o,
    output logic [MOD_W-1:0] deser_mod_o,
    output logic             deser_data_val_o,
    input  logic             deser_ready_i,
    output logic             busy_o,
    output logic             overflow_o
);

    // One extra bit so a full word's count (W) is representable.
    localparam int unsigned CW = MOD_W + 1;

    logic [W-1:0]     sr;
    logic [W-1:0]     sr_nxt;
    logic [MOD_W-1:0] cnt;
    logic [MOD_W-1:0] cnt_nxt;
    logic [CW-1:0]    n_bits;
    logic [CW-1:0]    shamt;
    logic             complete;
    logic [W-1:0]     word;
    logic [MOD_W-1:0] word_mod;

    // Shift in the new bit, then decide whether this cycle closes a word.
    always_comb begin
        sr_nxt   = sr;
        n_bits   = CW'(cnt);
        if (ser_data_val_i) begin
            sr_nxt = {sr[W-2:0], ser_data_i};
            n_bits = CW'(cnt) + CW'(1);
        end
        complete = (n_bits == CW'(W)) || (flush_i && (n_bits != '0));
        shamt    = CW'(W) - n_bits;
        word     = sr_nxt << shamt;
        word_mod = MOD_W'(mod_of(32'(n_bits), W));
        cnt_nxt  = complete ? '0 : n_bits[MOD_W-1:0];
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sr     <= '0;
            cnt    <= '0;
            busy_o <= 1'b0;
        end else begin
            sr     <= complete ? '0 : sr_nxt;
            cnt    <= cnt_nxt;
            busy_o <= (cnt_nxt != '0);
        end
    end

    deser_out_slot #(
        .W     (W),
        .MOD_W (MOD_W)
    ) u_slot (
        .clk       (clk_i),
        .rst_n     (arst_n_i),
        .push      (complete),
        .push_data (word),
        .push_mod  (word_mod),
        .ready     (deser_ready_i),
        .data      (deser_data_o),
        .mod       (deser_mod_o),
        .val       (deser_data_val_o),
        .overflow  (overflow_o)
    );

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: bit-queue reference model compared every cycle plus literal pins.
module tb_deserializer;
    import deser_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned MW = MOD_W;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          ser_data = 1'b0;
    logic          ser_val = 1'b0;
    logic          flush = 1'b0;
    logic          ready = 1'b1;
    logic [W-1:0]  data;
    logic [MW-1:0] mod;
    logic          val;
    logic          busy;
    logic          ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    deserializer #(.W(W)) dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
        .ser_data_i       (ser_data),
        .ser_data_val_i   (ser_val),
        .flush_i          (flush),
        .deser_data_o     (data),
        .deser_mod_o      (mod),
        .deser_data_val_o (val),
        .deser_ready_i    (ready),
        .busy_o           (busy),
        .overflow_o       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of received bits, packed into a word when it fills or is flushed.
    bit           bits[$];
    logic [W-1:0] m_data = '0;
    int           m_mod  = 0;
    logic         m_val  = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_ovf  = 1'b0;
    logic         m_free;
    logic         m_done;
    logic [W-1:0] m_word;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bits.delete();
            m_data = '0; m_mod = 0; m_val = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
        end else begin
            m_free = !m_val || ready;
            m_done = 1'b0;
            if (ser_val) bits.push_back(ser_data);
            if (bits.size() == W || (flush && bits.size() > 0)) begin
                m_word = '0;
                foreach (bits[i]) m_word[W-1-i] = bits[i];
                if (m_free) begin
                    m_val  = 1'b1;
                    m_data = m_word;
                    m_mod  = bits.size() % W;
                end else begin
                    m_ovf = 1'b1;
                end
                bits.delete();
                m_done = 1'b1;
            end
            if (!m_done && m_val && ready) m_val = 1'b0;
            m_busy = (bits.size() != 0);
        end
    end

    always @(negedge clk) begin
        check("val", 64'(val), 64'(m_val));
        check("busy", 64'(busy), 64'(m_busy));
        check("overflow", 64'(ovf), 64'(m_ovf));
        if (m_val) begin
            check("data", 64'(data), 64'(m_data));
            check("mod", 64'(mod), 64'(m_mod));
        end
    end

    // Handshake timestamps for the back-to-back spacing check.
    logic rec = 1'b0;
    int   acc_cyc[$];
    always @(negedge clk) if (rec && val && ready) acc_cyc.push_back(cyc);

    task automatic drive(input logic b, input logic v, input logic f);
        @(negedge clk);
        ser_data = b; ser_val = v; flush = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic flush_last);
        for (int i = W - 1; i >= 0; i--) drive(w[i], 1'b1, (i == 0) && flush_last);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_val", 64'(val), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        arst_n = 1'b1;

        // 1: single full word
        send_word(16'h6CF1, 1'b0);
        idle(1);
        check("t1_val", 64'(val), 64'd1);
        check("t1_data", 64'(data), 64'h6CF1);
        check("t1_mod", 64'(mod), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        idle(1);
        check("t1_val_drop", 64'(val), 64'd0);

        // 2: back-to-back words
        rec = 1'b1;
        send_word(16'h8C11, 1'b0);
        send_word(16'h9A2F, 1'b0);
        idle(1);
        check("t2_data2", 64'(data), 64'h9A2F);
        idle(1);
        rec = 1'b0;
        check("t2_count", 64'(acc_cyc.size()), 64'd2);
        if (acc_cyc.size() == 2) check("t2_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd16);
        check("t2_ovf", 64'(ovf), 64'd0);

        // 3: gapped partial word closed by flush
        drive(1'b0, 1'b1, 1'b0); idle(2);
        drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0); idle(1);
        drive(1'b0, 1'b1, 1'b0); idle(3);
        drive(1'b1, 1'b1, 1'b0); idle(1);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_noval", 64'(val), 64'd0);
        drive(1'b0, 1'b0, 1'b1);
        idle(1);
        check("t3_val", 64'(val), 64'd1);
        check("t3_data", 64'(data), 64'h6800);
        check("t3_mod", 64'(mod), 64'd5);
        check("t3_busy_after", 64'(busy), 64'd0);
        idle(1);

        // 4: stalled output, second word dropped
        ready = 1'b0;
        send_word(16'hACA9, 1'b0);
        idle(1);
        check("t4_held", 64'(data), 64'hACA9);
        send_word(16'h6CF1, 1'b0);
        check("t4_ovf_before", 64'(ovf), 64'd0);
        idle(1);
        check("t4_ovf", 64'(ovf), 64'd1);
        check("t4_data_kept", 64'(data), 64'hACA9);
        check("t4_val_kept", 64'(val), 64'd1);
        ready = 1'b1;
        idle(1);
        check("t4_accepted", 64'(val), 64'd0);
        check("t4_ovf_sticky", 64'(ovf), 64'd1);

        // 5: async reset mid-word
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0);
        idle(1);
        check("t5_busy_pre", 64'(busy), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        check("t5_busy_rst", 64'(busy), 64'd0);
        check("t5_ovf_rst", 64'(ovf), 64'd0);
        check("t5_val_rst", 64'(val), 64'd0);
        check("t5_data_rst", 64'(data), 64'd0);
        @(negedge clk);
        #2 arst_n = 1'b1;
        send_word(16'h9A2F, 1'b0);
        idle(1);
        check("t5_val", 64'(val), 64'd1);
        check("t5_data", 64'(data), 64'h9A2F);
        check("t5_mod", 64'(mod), 64'd0);
        idle(1);

        // 6: flush edge cases
        send_word(16'h1111, 1'b1);
        idle(1);
        check("t6_full_val", 64'(val), 64'd1);
        check("t6_full_data", 64'(data), 64'h1111);
        check("t6_full_mod", 64'(mod), 64'd0);
        idle(1);
        check("t6_no_extra", 64'(val), 64'd0);
        drive(1'b0, 1'b0, 1'b1);
        idle(1);
        check("t6_empty_flush", 64'(val), 64'd0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        idle(1);
        check("t6_part_val", 64'(val), 64'd1);
        check("t6_part_data", 64'(data), 64'hA000);
        check("t6_part_mod", 64'(mod), 64'd3);
        check("t6_part_busy", 64'(busy), 64'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Downstream stage of the bit serializer. Consumes the MSB-first bit stream (ser_data/ser_data_val) and reassembles it into parallel words.
- Presents each word on a valid/ready output register holding one word. Counts are encoded the same way as the serializer's data_mod, with 0 meaning a full word.
- An explicit flush emits a partial word, so frames shorter than the full width (data_mod 3..15 on the serializer side) can be recovered.

Parameters:
- W, 16, output word width in bits; legal range 2..64.
- MOD_W, $clog2(W), width of the bit-count field; derived, never overridden.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- arst_n_i  in  1  asynchronous active-low reset.
- ser_data_i  in  1  serial bit, MSB of word first.
- ser_data_val_i  in  1  ser_data_i is valid this cycle.
- flush_i  in  1  close the current partial word and emit it.
- deser_data_o  out  W  assembled word, left-aligned, unused LSBs zero.
- deser_mod_o  out  MOD_W  number of valid bits in deser_data_o; 0 = all W.
- deser_data_val_o  out  1  output word valid.
- deser_ready_i  in  1  downstream accepts word when val & ready.
- busy_o  out  1  partial word in progress (bit count != 0).
- overflow_o  out  1  sticky: a completed word was dropped.

Behaviour:

Reset:
- arst_n_i low asynchronously clears all state immediately, mid-word or mid-hold.
- Reset values: deser_data_o=0, deser_mod_o=0, deser_data_val_o=0, busy_o=0, overflow_o=0.
- Shift register and bit counter cnt are also cleared.

Accumulation:
- Each cycle with ser_data_val_i=1: sr <= {sr[W-2:0], ser_data_i}, cnt <= cnt+1.
- Bits with ser_data_val_i=0 are ignored. Gaps between bits are allowed and do not reset cnt.

Completion:
- A word completes on either event:
  - the W-th valid bit arrives (cnt==W-1 & val): full word, mod=0;
  - flush_i=1 with at least one bit pending, counting a bit arriving in the same cycle: partial word, mod=count.
- Partial-word packing: first received bit at deser_data_o[W-1], zeros below the last received bit.
- flush_i in the same cycle as the W-th bit produces one full word with mod=0, never an extra empty word.
- flush_i with cnt==0 and no valid bit has no effect.
- On completion cnt <= 0.

Latency:
- deser_data_val_o rises on the cycle after completion.
- data/mod are stable while val=1 and ready=0.

Output slot:
- The slot is free when val=0, or when val & ready in the same cycle (a completion may overwrite an accepted word, giving back-to-back words with no bubble).
- val falls on the cycle after acceptance unless a new word loads in that same cycle.
- If a word completes while the slot is occupied and not being accepted:
  - the new word is dropped and the held word is kept unchanged;
  - overflow_o is set from the next cycle and stays set until reset.

Flags:
- busy_o = (cnt != 0), registered.
- A word completed by flush goes to the output slot, not to busy.

State:
- No explicit FSM beyond cnt and the slot-full flag. cnt wraps W-1 -> 0 only through completion.

Decomposition:
- deser_pkg holds: default W; function mod_of(count) returning count mod W (0 for full); localparam MOD_W.
- No sub-module required. The single-entry output slot may be split out as deser_out_slot (data, mod, val, ready, load, drop) if reused by sibling stages; ~40 lines.
- Expected RTL size ~130 lines.

Test Plan (W=16, all vectors sent MSB first):
1. 16 contiguous bits of 16'h6CF1, ready=1 -> one cycle after the 16th bit: val=1 for 1 cycle, data=16'h6CF1, mod=0, busy=0, overflow=0.
2. 16'h8C11 then 16'h9A2F back-to-back, ready=1 -> two single-cycle valids exactly 16 cycles apart, correct data, no overflow.
3. Bits 0,1,1,0,1 with random val gaps, then flush_i alone -> data=16'h6800, mod=5. busy=1 during the bits, 0 after the flush.
4. ready=0, send 16'hAC A9 then 16'h6CF1:
   - first word is held; overflow=1 on the cycle after the second word's last bit;
   - data stays 16'hACA9;
   - raising ready -> one accept, then val=0.
5. Reset:
   - arst_n_i pulsed low asynchronously (not on a clock edge) after 7 bits -> all outputs 0 immediately;
   - next 16 bits of 16'h9A2F -> a clean word with mod=0.
6. Flush edge cases:
   - flush_i together with the 16th bit of 16'h1111 -> exactly one word, mod=0;
   - flush_i with cnt=0 -> no valid;
   - flush_i together with the 3rd bit (1,0,1) -> data=16'hA000, mod=3.
